// File: rtl/lcd_pkg.sv
// Shared LCD definitions: HD44780 command/character constants, line geometry and the line-writer FSM states.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_CHAR_SPACE    = 8'h20;
  localparam int         LCD_LINE_CHARS    = 16;
  localparam int         LCD_LINE_BITS     = LCD_LINE_CHARS * 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CURSOR,
    ST_CHAR,
    ST_DONE
  } lcd_state_t;

  // NUL bytes in a producer's line are shown as blanks rather than CGRAM glyph 0.
  function automatic logic [7:0] lcd_printable(input logic [7:0] c);
    return (c == 8'h00) ? LCD_CHAR_SPACE : c;
  endfunction

endpackage

// File: rtl/lcd_line_arbiter_if.sv
// Producer-side request bus plus the byte channel toward the LCD bus controller.
interface lcd_line_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     req_row;
  logic [NUM_REQ*128-1:0] req_line;
  logic [NUM_REQ-1:0]     grant;
  logic [NUM_REQ-1:0]     done;
  logic                   busy;
  logic                   lcd_valid;
  logic                   lcd_rs;
  logic [7:0]             lcd_data;
  logic                   lcd_ready;

  modport master (
    output req, req_row, req_line, lcd_ready,
    input  grant, done, busy, lcd_valid, lcd_rs, lcd_data
  );

  modport slave (
    input  req, req_row, req_line, lcd_ready,
    output grant, done, busy, lcd_valid, lcd_rs, lcd_data
  );

endinterface

// File: rtl/lcd_rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1 with wrap.
// Zero latency; no flow control of its own.
module lcd_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [IDX_W-1:0]   o_winner,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic               o_any_req
);

  int w_cand;

  // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    o_onehot  = '0;
    w_cand    = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_cand = (int'(i_last_grant) + off) % NUM_REQ;
      if (i_req[IDX_W'(w_cand)]) begin
        o_winner  = IDX_W'(w_cand);
        o_any_req = 1'b1;
      end
    end
    if (o_any_req) begin
      o_onehot[o_winner] = 1'b1;
    end
  end

endmodule

// File: rtl/lcd_line_arbiter.sv
// Shares one LCD byte channel among NUM_REQ line producers: cursor command + 16 chars per grant.
// With lcd_ready high a line takes 19 cycles grant-to-idle; each byte holds until lcd_valid && lcd_ready.
module lcd_line_arbiter
  import lcd_pkg::*;
#(
  parameter int         NUM_REQ   = 4,
  parameter logic [7:0] ROW1_ADDR = 8'h40
) (
  input logic               clk,
  input logic               rst,
  lcd_line_arbiter_if.slave bus
);

  localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [3:0]       CHAR_END = 4'(LCD_LINE_CHARS - 1);

  lcd_state_t          r_state;
  logic [7:0]          r_chars [LCD_LINE_CHARS];
  logic [3:0]          r_idx;
  logic [IDX_W-1:0]    r_last_grant;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_done;
  logic                r_busy;
  logic                r_lcd_valid;
  logic                r_lcd_rs;
  logic [7:0]          r_lcd_data;

  logic [IDX_W-1:0]         w_winner;
  logic [NUM_REQ-1:0]       w_onehot;
  logic                     w_any_req;
  logic                     w_hs;
  logic [3:0]               w_idx_nxt;
  logic [LCD_LINE_BITS-1:0] w_lines     [NUM_REQ];
  logic [7:0]               w_win_chars [LCD_LINE_CHARS];

  lcd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req        (bus.req),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_onehot     (w_onehot),
    .o_any_req    (w_any_req)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_lines[g] = bus.req_line[g*LCD_LINE_BITS +: LCD_LINE_BITS];
  end

  for (genvar k = 0; k < LCD_LINE_CHARS; k++) begin : g_chr
    assign w_win_chars[k] = w_lines[w_winner][k*8 +: 8];
  end

  assign w_hs      = r_lcd_valid & bus.lcd_ready;
  assign w_idx_nxt = r_idx + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_last_grant <= LAST_IDX;
      r_grant      <= '0;
      r_done       <= '0;
      r_busy       <= 1'b0;
      r_lcd_valid  <= 1'b0;
      r_lcd_rs     <= 1'b0;
      r_lcd_data   <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_chars      <= w_win_chars;
            r_grant      <= w_onehot;
            r_busy       <= 1'b1;
            r_last_grant <= w_winner;
            r_lcd_valid  <= 1'b1;
            r_lcd_rs     <= 1'b0;
            r_lcd_data   <= LCD_CMD_SET_DDRAM | (bus.req_row[w_winner] ? ROW1_ADDR : 8'h00);
            r_state      <= ST_CURSOR;
          end
        end
        ST_CURSOR: begin
          if (w_hs) begin
            r_idx      <= '0;
            r_lcd_rs   <= 1'b1;
            r_lcd_data <= lcd_printable(r_chars[0]);
            r_state    <= ST_CHAR;
          end
        end
        ST_CHAR: begin
          if (w_hs) begin
            if (r_idx == CHAR_END) begin
              r_lcd_valid <= 1'b0;
              r_done      <= r_grant;
              r_state     <= ST_DONE;
            end else begin
              r_idx      <= w_idx_nxt;
              r_lcd_data <= lcd_printable(r_chars[w_idx_nxt]);
            end
          end
        end
        ST_DONE: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
  assign bus.lcd_valid = r_lcd_valid;
  assign bus.lcd_rs    = r_lcd_rs;
  assign bus.lcd_data  = r_lcd_data;

endmodule

// File: tb/tb_lcd_line_arbiter.sv
// Randomized bench for lcd_line_arbiter, checked against a line/round-robin reference model.
module tb_lcd_line_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lcd_line_arbiter_if #(.NUM_REQ(N)) bus ();

  lcd_line_arbiter #(.NUM_REQ(N), .ROW1_ADDR(8'h40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [8:0]   hs_q[$];
  logic [8:0]   exp_q[$];
  int           done_cyc_q[$];
  int           grant_cyc_q[$];
  logic [N-1:0] done_vec_q[$];
  logic [N-1:0] grant_vec_q[$];
  logic [N-1:0] prev_grant = '0;
  logic         prev_stall = 1'b0;
  logic [8:0]   prev_byte  = '0;
  bit           rand_rdy   = 1'b0;
  logic [127:0] lines [N];
  int           model_last = N - 1;

  // Bus monitor: a byte observed with valid && ready here is accepted at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (prev_stall && bus.lcd_valid) begin
        n_checks++;
        if ({bus.lcd_rs, bus.lcd_data} !== prev_byte) begin
          n_fail++;
          $display("FAIL stall_stable: got rs=%b data=%h, held byte was rs=%b data=%h",
                   bus.lcd_rs, bus.lcd_data, prev_byte[8], prev_byte[7:0]);
        end
      end
      prev_stall = bus.lcd_valid && !bus.lcd_ready;
      prev_byte  = {bus.lcd_rs, bus.lcd_data};
      if (bus.lcd_valid && bus.lcd_ready) hs_q.push_back({bus.lcd_rs, bus.lcd_data});
      if (bus.done != '0) begin
        done_cyc_q.push_back(cyc);
        done_vec_q.push_back(bus.done);
      end
      if (bus.grant != '0 && prev_grant == '0) begin
        grant_cyc_q.push_back(cyc);
        grant_vec_q.push_back(bus.grant);
      end
    end else begin
      prev_stall = 1'b0;
    end
    prev_grant = bus.grant;
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) bus.lcd_ready = 1'($urandom_range(0, 1));
  end

  // Reference: cursor command for the row, then the 16 chars left to right with NUL shown as space.
  function automatic void push_expected(input logic [127:0] l, input logic row);
    logic [127:0] t;
    t = l;
    exp_q.push_back({1'b0, row ? 8'hC0 : 8'h80});
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back({1'b1, (t[7:0] == 8'h00) ? 8'h20 : t[7:0]});
      t = t >> 8;
    end
  endfunction

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    int w;
    w = -1;
    for (int off = 1; off <= N; off++)
      if (w < 0 && m[(last + off) % N]) w = (last + off) % N;
    return w;
  endfunction

  function automatic void clear_logs();
    hs_q.delete();
    exp_q.delete();
    done_cyc_q.delete();
    done_vec_q.delete();
    grant_cyc_q.delete();
    grant_vec_q.delete();
  endfunction

  function automatic void pack_lines();
    logic [N*128-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v = {lines[i], v[N*128-1:128]};
    bus.req_line = v;
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_dones(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (done_cyc_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.req_row = '0;
    bus.req_line = '0;
    bus.lcd_ready = 1'b1;
    for (int i = 0; i < N; i++) lines[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (bus.grant !== '0)   begin n_fail++; $display("FAIL reset_grant: got %b want 0", bus.grant); end
    n_checks++; if (bus.done !== '0)    begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.lcd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.lcd_valid); end
    n_checks++; if (bus.lcd_rs !== 1'b0) begin n_fail++; $display("FAIL reset_rs: got %b want 0", bus.lcd_rs); end
    n_checks++; if (bus.lcd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.lcd_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = N - 1;
  endtask

  task automatic test_single();
    string s;
    int    k0;
    bit    ok;
    s = "AAAABBBBCCCCABCD";
    for (int k = 0; k < 16; k++) lines[0] = {s[k], lines[0][127:8]};
    bus.req_row = '0;
    pack_lines();
    clear_logs();
    push_expected(lines[0], 1'b0);
    @(posedge clk); #1;
    k0 = cyc;
    bus.req = 4'b0001;
    wait_dones(1, 60, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: no done in 60 cycles"); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_at_done: got %b want 1", bus.busy); end
    bus.req = '0;
    n_checks++;
    if (grant_cyc_q.size() != 1 || grant_cyc_q[0] != k0 + 2) begin
      n_fail++; $display("FAIL single_grant_cycle: got %0d grants first at %0d want 1 at %0d",
                         grant_cyc_q.size(), (grant_cyc_q.size() > 0) ? grant_cyc_q[0] : -1, k0 + 2);
    end
    n_checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != k0 + 19 || done_vec_q[0] !== 4'b0001) begin
      n_fail++; $display("FAIL single_done: got %0d pulses at %0d vec %b want 1 at %0d vec 0001",
                         done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1,
                         (done_vec_q.size() > 0) ? done_vec_q[0] : 4'b0, k0 + 19);
    end
    @(negedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0)  begin n_fail++; $display("FAIL single_busy_after: got %b want 0", bus.busy); end
    n_checks++; if (bus.grant !== '0)   begin n_fail++; $display("FAIL single_grant_after: got %b want 0", bus.grant); end
    n_checks++;
    if (hs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d want %0d", hs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
      n_checks++;
      if (hs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL single_byte[%0d]: got rs=%b data=%h want rs=%b data=%h",
                           i, hs_q[i][8], hs_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
      end
    end
    model_last = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_row1_nulls();
    logic [7:0] b;
    bit         ok;
    for (int k = 0; k < 16; k++) begin
      b = (k < 5) ? 8'($urandom_range(1, 255)) : 8'h00;
      lines[2] = {b, lines[2][127:8]};
    end
    bus.req_row = 4'($urandom) | 4'b0100;
    pack_lines();
    clear_logs();
    push_expected(lines[2], 1'b1);
    @(posedge clk); #1;
    bus.req = 4'b0100;
    wait_dones(1, 60, ok);
    bus.req = '0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL row1_timeout: no done in 60 cycles"); end
    n_checks++;
    if (hs_q.size() == 0 || hs_q[0] !== 9'h0C0) begin
      n_fail++; $display("FAIL row1_cursor: got %h want 0C0", (hs_q.size() > 0) ? hs_q[0] : 9'h1FF);
    end
    n_checks++;
    if (done_vec_q.size() != 1 || done_vec_q[0] !== 4'b0100) begin
      n_fail++; $display("FAIL row1_done: got %0d pulses vec %b want 1 vec 0100",
                         done_vec_q.size(), (done_vec_q.size() > 0) ? done_vec_q[0] : 4'b0);
    end
    n_checks++;
    if (hs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL row1_count: got %0d want %0d", hs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
      n_checks++;
      if (hs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL row1_byte[%0d]: got %h want %h", i, hs_q[i], exp_q[i]);
      end
    end
    model_last = 2;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_round_robin();
    int order [5];
    int last;
    bit ok;
    for (int i = 0; i < N; i++) lines[i] = rand_line();
    bus.req_row = 4'($urandom);
    pack_lines();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_last = N - 1;
    clear_logs();
    last = model_last;
    for (int j = 0; j < 5; j++) begin
      order[j] = rr_pick(4'b1111, last);
      push_expected(lines[order[j]], bus.req_row[order[j]]);
      last = order[j];
    end
    bus.req = 4'b1111;
    wait_dones(5, 5 * 19 + 20, ok);
    bus.req = '0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d dones want 5", done_cyc_q.size()); end
    n_checks++;
    if (grant_vec_q.size() != 5 || done_vec_q.size() != 5) begin
      n_fail++; $display("FAIL rr_counts: got %0d grants %0d dones want 5 and 5", grant_vec_q.size(), done_vec_q.size());
    end
    for (int j = 0; j < 5 && j < grant_vec_q.size() && j < done_vec_q.size(); j++) begin
      n_checks++;
      if (grant_vec_q[j] !== (4'b0001 << order[j]) || done_vec_q[j] !== (4'b0001 << order[j])) begin
        n_fail++; $display("FAIL rr_order[%0d]: got grant %b done %b want requester %0d",
                           j, grant_vec_q[j], done_vec_q[j], order[j]);
      end
      if (j > 0) begin
        n_checks++;
        if (done_cyc_q[j] - done_cyc_q[j-1] != 19) begin
          n_fail++; $display("FAIL rr_spacing[%0d]: got %0d cycles want 19", j, done_cyc_q[j] - done_cyc_q[j-1]);
        end
      end
    end
    n_checks++;
    if (hs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rr_count: got %0d want %0d", hs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
      n_checks++;
      if (hs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rr_byte[%0d]: got %h want %h", i, hs_q[i], exp_q[i]);
      end
    end
    model_last = order[4];
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random_ready();
    int r;
    bit row;
    bit ok;
    rand_rdy = 1'b1;
    for (int it = 0; it < 3; it++) begin
      r = $urandom_range(0, N - 1);
      row = 1'($urandom_range(0, 1));
      lines[r] = rand_line();
      bus.req_row[r] = row;
      pack_lines();
      clear_logs();
      push_expected(lines[r], row);
      @(posedge clk); #2;
      bus.req = '0;
      bus.req[r] = 1'b1;
      wait_dones(1, 400, ok);
      bus.req = '0;
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rdy_timeout[%0d]: no done in 400 cycles", it); end
      n_checks++;
      if (done_vec_q.size() != 1 || done_vec_q[0] !== (4'b0001 << r)) begin
        n_fail++; $display("FAIL rdy_done[%0d]: got %0d pulses vec %b want requester %0d",
                           it, done_vec_q.size(), (done_vec_q.size() > 0) ? done_vec_q[0] : 4'b0, r);
      end
      n_checks++;
      if (hs_q.size() != 17) begin n_fail++; $display("FAIL rdy_count[%0d]: got %0d want 17", it, hs_q.size()); end
      for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
        n_checks++;
        if (hs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rdy_byte[%0d][%0d]: got %h want %h", it, i, hs_q[i], exp_q[i]);
        end
      end
      model_last = r;
      repeat (2) @(posedge clk);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    bus.lcd_ready = 1'b1;
  endtask

  task automatic test_latched_change();
    bit ok;
    bit seen;
    lines[3] = rand_line();
    bus.req_row[3] = 1'b0;
    pack_lines();
    clear_logs();
    push_expected(lines[3], 1'b0);
    @(posedge clk); #1;
    bus.req = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (grant_vec_q.size() > 0);
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL latch_grant_timeout: no grant in 10 cycles"); end
    lines[3] = ~lines[3];
    bus.req_row[3] = 1'b1;
    pack_lines();
    repeat (5) @(posedge clk);
    #1;
    bus.req = '0;
    wait_dones(1, 40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL latch_timeout: no done after req dropped"); end
    n_checks++;
    if (done_vec_q.size() != 1 || done_vec_q[0] !== 4'b1000) begin
      n_fail++; $display("FAIL latch_done: got %0d pulses vec %b want 1 vec 1000",
                         done_vec_q.size(), (done_vec_q.size() > 0) ? done_vec_q[0] : 4'b0);
    end
    n_checks++;
    if (hs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL latch_count: got %0d want %0d", hs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
      n_checks++;
      if (hs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL latch_byte[%0d]: got %h want %h", i, hs_q[i], exp_q[i]);
      end
    end
    model_last = 3;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int w0, w1;
    lines[1] = rand_line();
    bus.req_row = 4'($urandom);
    pack_lines();
    clear_logs();
    @(posedge clk); #1;
    bus.req = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (hs_q.size() >= 9);
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL abort_reach_char7: got %0d handshakes want 9", hs_q.size()); end
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (bus.lcd_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", bus.lcd_valid); end
    n_checks++; if (bus.grant !== '0)       begin n_fail++; $display("FAIL abort_grant: got %b want 0", bus.grant); end
    n_checks++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_checks++;
    if (bus.done !== '0 || done_cyc_q.size() != 0) begin
      n_fail++; $display("FAIL abort_no_done: got done %b and %0d pulses want none", bus.done, done_cyc_q.size());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = N - 1;
    bus.req = '0;
    clear_logs();
    w0 = rr_pick(4'b1010, model_last);
    w1 = rr_pick(4'b1010, w0);
    push_expected(lines[w0], bus.req_row[w0]);
    push_expected(lines[w1], bus.req_row[w1]);
    @(posedge clk); #1;
    bus.req = 4'b1010;
    wait_dones(2, 80, ok);
    bus.req = '0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL post_reset_timeout: got %0d dones want 2", done_cyc_q.size()); end
    n_checks++;
    if (grant_vec_q.size() != 2 || grant_vec_q[0] !== (4'b0001 << w0) || grant_vec_q[1] !== (4'b0001 << w1)) begin
      n_fail++; $display("FAIL post_reset_order: got %0d grants first %b want %0d then %0d",
                         grant_vec_q.size(), (grant_vec_q.size() > 0) ? grant_vec_q[0] : 4'b0, w0, w1);
    end
    n_checks++;
    if (hs_q.size() == 0 || hs_q[0][8] !== 1'b0 || (hs_q[0][7:0] & 8'hBF) !== 8'h80) begin
      n_fail++; $display("FAIL post_reset_cursor: got %h want cursor command first", (hs_q.size() > 0) ? hs_q[0] : 9'h1FF);
    end
    n_checks++;
    if (hs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL post_reset_count: got %0d want %0d", hs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
      n_checks++;
      if (hs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL post_reset_byte[%0d]: got %h want %h", i, hs_q[i], exp_q[i]);
      end
    end
    model_last = w1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_row1_nulls();
    test_round_robin();
    test_random_ready();
    test_latched_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_line_arbiter.md
Name: lcd_line_arbiter

Overview:
Shares one HD44780-style LCD command/data channel between NUM_REQ line producers, such as hash status or progress displays.
- Each requester submits a 16-char line plus a row select.
- The block arbitrates round-robin and latches the winning line.
- It emits a set-DDRAM-address command, then 16 character writes, then signals completion to the winner.
- It sits between the line producers and the LCD bus controller, replacing per-producer line writers.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ROW1_ADDR, 8'h40, DDRAM base address of row 1 (row 0 base is 8'h00)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  per-requester request; hold high until matching done pulse
req_row  in  NUM_REQ  per-requester target row (0/1)
req_line  in  NUM_REQ*128  per-requester line; requester i uses bits [i*128+127 : i*128]; char k = bits [k*8+7 : k*8], k=0 leftmost
grant  out  NUM_REQ  one-hot owner of the current transfer; all-zero when idle
done  out  NUM_REQ  one-cycle pulse on the owner's bit when its line is fully written
busy  out  1  high from grant until the done cycle inclusive
lcd_valid  out  1  command/data valid to LCD controller
lcd_rs  out  1  0 = instruction byte, 1 = character data
lcd_data  out  8  byte to LCD controller
lcd_ready  in  1  controller accepts the byte in any cycle where lcd_valid && lcd_ready (handshake)

Behaviour:
- All outputs are registered. On reset: grant=0, done=0, busy=0, lcd_valid=0, lcd_rs=0, lcd_data=0, state=IDLE, char index=0, last_grant=NUM_REQ-1 (so requester 0 wins first).
- Reset mid-transfer aborts immediately: lcd_valid drops the next cycle, no done is issued, and the partial line is left on the display.
- IDLE:
  - If any req bit is high, pick the winner by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - At that edge: latch req_line/req_row of the winner, set grant one-hot, busy=1, last_grant=winner, go to CURSOR.
- CURSOR:
  - lcd_valid=1, lcd_rs=0, lcd_data = 8'h80 | (row ? ROW1_ADDR : 8'h00).
  - Hold all three stable until handshake.
  - On handshake: index=0, go to CHAR.
- CHAR:
  - lcd_valid=1, lcd_rs=1, lcd_data = latched char[index], with 8'h00 substituted by 8'h20 (space).
  - Hold until handshake, then index++.
  - Handshake with index==15 goes to DONE.
- DONE:
  - lcd_valid=0, done[winner]=1 for this single cycle, busy=1.
  - Next cycle: grant=0, busy=0, state=IDLE.
  - req is not sampled in DONE.
- Data stability: lcd_data/lcd_rs must not change while lcd_valid=1 and lcd_ready=0.
- req changes and req_line changes after grant are ignored; the transfer uses the latched copy.
- A requester deasserting req mid-transfer does not abort the transfer.
- Latency with lcd_ready tied high:
  - req sampled at edge 0.
  - CURSOR handshake in cycle 1, chars in cycles 2..17.
  - done in cycle 18, IDLE in cycle 19.
  - Next grant earliest at edge ending cycle 19.
  - Back-to-back throughput: one line per 19 cycles.
- Simultaneous requests: exactly one grant; the others wait with no loss.
- A requester that keeps req high after done is re-granted only after the others, per round-robin.
- Only the low bit of req_row is meaningful; the row is latched at grant.
- Index counter is 4 bits and never wraps past 15 inside CHAR.

Decomposition:
- Shared package (lcd_pkg):
  - LCD_CMD_SET_DDRAM=8'h80
  - LCD_CHAR_SPACE=8'h20
  - LCD_LINE_CHARS=16
  - state encoding IDLE/CURSOR/CHAR/DONE
- Sub-module lcd_rr_arbiter: combinational round-robin picker.
  - Inputs: req, last_grant.
  - Outputs: winner index and one-hot, any_req.
  - Reused by future shared LCD/UART resources.

Test Plan:
- Single requester 0, row 0, line "AAAABBBBCCCCABCD", lcd_ready=1 -> handshakes 0x80 then 0x41×4, 0x42×4, 0x43×4, 0x41 0x42 0x43 0x44; done[0] in cycle 18; busy low in cycle 19.
- Requester 2, row 1, line with bytes 5..15 = 8'h00 -> first byte 0xC0 (rs=0); chars 5..15 emitted as 0x20.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0; each done pulse exactly one cycle on the matching bit.
- lcd_ready toggling pseudo-randomly -> lcd_data/lcd_rs stable while stalled; exactly 17 handshakes per line; the byte sequence matches the ready-high case.
- req_line of the owner changed after grant, and its req dropped mid-transfer -> original latched line completes and done is still pulsed.
- rst asserted during char 7 -> next cycle lcd_valid=0, grant=0, busy=0, no done. After release, req=4'b0010 -> requester 1 is granted (last_grant was reset to NUM_REQ-1) and sends 0x80 first.
